// File: rtl/lane_swizzle_pkg.sv
// Shared types for the lane swizzle register: swizzle mode encoding and rot-port sizing.
package lane_swizzle_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_REV  = 2'd1,
        MODE_PAIR = 2'd2,
        MODE_ROT  = 2'd3
    } mode_t;

    // Width of the rotate-amount port: max(1, clog2(lanes)).
    function automatic int rot_w(input int lanes);
        return (lanes > 2) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/lane_swizzle_perm.sv
// Combinational lane permutation (pass, reverse, pair swap, rotate).
// Rotation exists only when LANE_SWIZZLE_ROT_EN is defined; otherwise mode 3 is a pass-through.
module lane_swizzle_perm
    import lane_swizzle_pkg::*;
#(
    parameter int LANE_W = 8,
    parameter int LANES  = 2
) (
    input  logic [LANE_W*LANES-1:0]   src_data,
    input  logic [1:0]                mode,
    input  logic [rot_w(LANES)-1:0]   rot,
    output logic [LANE_W*LANES-1:0]   perm_data
);

    int src_lane;

`ifndef LANE_SWIZZLE_ROT_EN
    logic unused_rot;
    assign unused_rot = ^rot;
`endif

    always_comb begin
        perm_data = src_data;
        src_lane  = 0;
        for (int i = 0; i < LANES; i++) begin
            case (mode_t'(mode))
                MODE_REV:  src_lane = LANES - 1 - i;
                // With odd LANES the top lane has no partner and stays put.
                MODE_PAIR: src_lane = ((i ^ 1) < LANES) ? (i ^ 1) : i;
`ifdef LANE_SWIZZLE_ROT_EN
                MODE_ROT:  src_lane = (i + int'(rot)) % LANES;
`endif
                default:   src_lane = i;
            endcase
            perm_data[i*LANE_W +: LANE_W] = src_data[src_lane*LANE_W +: LANE_W];
        end
    end

endmodule

// File: rtl/lane_swizzle_reg.sv
// Two-entry FIFO that stores words already lane-swizzled on the input side.
// Define LANE_SWIZZLE_ROT_EN to enable the mode-3 lane rotation.
module lane_swizzle_reg
    import lane_swizzle_pkg::*;
#(
    parameter int LANE_W = 8,
    parameter int LANES  = 2
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANE_W*LANES-1:0]   in_data,
    input  logic [1:0]                mode,
    input  logic [rot_w(LANES)-1:0]   rot,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANE_W*LANES-1:0]   out_data,
    output logic [1:0]                count
);

    localparam int W = LANE_W * LANES;

    logic [W-1:0] swz_data;
    logic [W-1:0] head_data;
    logic [W-1:0] tail_data;
    logic [1:0]   count_q;
    logic         push;
    logic         pop;

    lane_swizzle_perm #(
        .LANE_W (LANE_W),
        .LANES  (LANES)
    ) u_perm (
        .src_data  (in_data),
        .mode      (mode),
        .rot       (rot),
        .perm_data (swz_data)
    );

    // Handshakes depend only on the registered count, never on out_ready.
    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = out_valid ? head_data : '0;
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q   <= 2'd0;
            head_data <= '0;
            tail_data <= '0;
        end else if (push && pop) begin
            // Only reachable at count 1: the new word replaces the departing head.
            head_data <= swz_data;
        end else if (push) begin
            if (count_q == 2'd0) begin
                head_data <= swz_data;
            end else begin
                tail_data <= swz_data;
            end
            count_q <= count_q + 2'd1;
        end else if (pop) begin
            head_data <= tail_data;
            tail_data <= '0;
            count_q   <= count_q - 2'd1;
        end
    end

endmodule

// File: tb/tb_lane_swizzle_reg.sv
// Directed bench for lane_swizzle_reg at LANES = 2, 3 and 4 with shared handshake controls.
module tb_lane_swizzle_reg;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  mode;
    logic [1:0]  rot;
    logic [31:0] din;

    logic        in_ready2, out_valid2, in_ready3, out_valid3, in_ready4, out_valid4;
    logic [15:0] out_data2;
    logic [23:0] out_data3;
    logic [31:0] out_data4;
    logic [1:0]  count2, count3, count4;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    lane_swizzle_reg #(.LANE_W(8), .LANES(2)) dut (
        .CLK(clk), .RESET(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(din[15:0]), .mode(mode), .rot(rot[0]), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .count(count2)
    );

    lane_swizzle_reg #(.LANE_W(8), .LANES(3)) dut3 (
        .CLK(clk), .RESET(rst), .in_valid(in_valid), .in_ready(in_ready3),
        .in_data(din[23:0]), .mode(mode), .rot(rot), .out_valid(out_valid3),
        .out_ready(out_ready), .out_data(out_data3), .count(count3)
    );

    lane_swizzle_reg #(.LANE_W(8), .LANES(4)) dut4 (
        .CLK(clk), .RESET(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(din), .mode(mode), .rot(rot), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4), .count(count4)
    );

    typedef struct {
        int          sel;
        logic [1:0]  mode;
        logic [1:0]  rot;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sel_data(input int sel);
        case (sel)
            2:       return {16'h0, out_data2};
            3:       return {8'h0, out_data3};
            default: return out_data4;
        endcase
    endfunction

    function automatic logic [31:0] sel_valid(input int sel);
        case (sel)
            2:       return {31'h0, out_valid2};
            3:       return {31'h0, out_valid3};
            default: return {31'h0, out_valid4};
        endcase
    endfunction

    function automatic logic [31:0] sel_count(input int sel);
        case (sel)
            2:       return {30'h0, count2};
            3:       return {30'h0, count3};
            default: return {30'h0, count4};
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        mode = 2'd0; rot = 2'd0; din = 32'h0;

        vecs[0]  = '{2, 2'd0, 2'd0, 32'h0000A1B2, 32'h0000A1B2};
        vecs[1]  = '{2, 2'd1, 2'd0, 32'h0000A1B2, 32'h0000B2A1};
        vecs[2]  = '{2, 2'd2, 2'd0, 32'h0000A1B2, 32'h0000B2A1};
        vecs[3]  = '{2, 2'd1, 2'd0, 32'h000000FF, 32'h0000FF00};
        vecs[4]  = '{2, 2'd3, 2'd0, 32'h00001234, 32'h00001234};
        vecs[5]  = '{3, 2'd2, 2'd0, 32'h00112233, 32'h00113322};
        vecs[6]  = '{3, 2'd1, 2'd0, 32'h00112233, 32'h00332211};
        vecs[7]  = '{4, 2'd1, 2'd0, 32'h11223344, 32'h44332211};
        vecs[8]  = '{4, 2'd2, 2'd0, 32'h11223344, 32'h22114433};
`ifdef LANE_SWIZZLE_ROT_EN
        vecs[9]  = '{2, 2'd3, 2'd1, 32'h00001234, 32'h00003412};
        vecs[10] = '{4, 2'd3, 2'd1, 32'h11223344, 32'h44112233};
        vecs[11] = '{4, 2'd3, 2'd3, 32'h11223344, 32'h22334411};
        vecs[12] = '{3, 2'd3, 2'd1, 32'h00112233, 32'h00331122};
        vecs[13] = '{3, 2'd3, 2'd3, 32'h00112233, 32'h00112233};
`else
        vecs[9]  = '{2, 2'd3, 2'd1, 32'h00001234, 32'h00001234};
        vecs[10] = '{4, 2'd3, 2'd1, 32'h11223344, 32'h11223344};
        vecs[11] = '{4, 2'd3, 2'd3, 32'h11223344, 32'h11223344};
        vecs[12] = '{3, 2'd3, 2'd1, 32'h00112233, 32'h00112233};
        vecs[13] = '{3, 2'd3, 2'd3, 32'h00112233, 32'h00112233};
`endif

        @(negedge clk);
        cycle();
        rst = 1'b0;
        chk("reset_count", {30'h0, count2}, 32'd0);
        chk("reset_in_ready", {31'h0, in_ready2}, 32'd1);
        chk("reset_out_valid", {31'h0, out_valid2}, 32'd0);
        chk("reset_out_data", {16'h0, out_data2}, 32'd0);

        // Table: push one word into an empty FIFO, check head, then drain it.
        foreach (vecs[k]) begin
            in_valid = 1'b1; out_ready = 1'b0;
            mode = vecs[k].mode; rot = vecs[k].rot; din = vecs[k].din;
            cycle();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", k), sel_valid(vecs[k].sel), 32'd1);
            chk($sformatf("vec%0d_data", k), sel_data(vecs[k].sel), vecs[k].exp);
            chk($sformatf("vec%0d_count", k), sel_count(vecs[k].sel), 32'd1);
            out_ready = 1'b1;
            cycle();
            out_ready = 1'b0;
            chk($sformatf("vec%0d_drain_count", k), sel_count(vecs[k].sel), 32'd0);
            chk($sformatf("vec%0d_idle_data", k), sel_data(vecs[k].sel), 32'd0);
        end

        // Fill to two, refuse a third, then drain in order.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0; mode = 2'd0; din = 32'h0001;
        cycle();
        mode = 2'd1; din = 32'h0002;
        cycle();
        chk("full_count", {30'h0, count2}, 32'd2);
        chk("full_in_ready", {31'h0, in_ready2}, 32'd0);
        mode = 2'd0; din = 32'h0003;
        cycle();
        chk("refused_count", {30'h0, count2}, 32'd2);
        chk("full_head", {16'h0, out_data2}, 32'h0001);
        in_valid = 1'b0; mode = 2'd1; out_ready = 1'b1;
        chk("mode_ignored_head", {16'h0, out_data2}, 32'h0001);
        cycle();
        chk("second_head", {16'h0, out_data2}, 32'h0200);
        chk("second_count", {30'h0, count2}, 32'd1);
        cycle();
        chk("drained_count", {30'h0, count2}, 32'd0);
        chk("drained_valid", {31'h0, out_valid2}, 32'd0);

        // Simultaneous push and pop at count 1.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0; mode = 2'd0; din = 32'h1111;
        cycle();
        chk("pp_head0", {16'h0, out_data2}, 32'h1111);
        din = 32'h2222; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("pp_count", {30'h0, count2}, 32'd1);
        chk("pp_head1", {16'h0, out_data2}, 32'h2222);
        cycle();
        chk("pp_drain", {30'h0, count2}, 32'd0);

        // Reset while full, with push and pop both requested.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0; mode = 2'd0; din = 32'hAAAA;
        cycle();
        din = 32'hBBBB;
        cycle();
        chk("pre_rst_count", {30'h0, count2}, 32'd2);
        rst = 1'b1; din = 32'hCCCC; out_ready = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_count", {30'h0, count2}, 32'd0);
        chk("rst_valid", {31'h0, out_valid2}, 32'd0);
        chk("rst_data", {16'h0, out_data2}, 32'd0);
        chk("rst_in_ready", {31'h0, in_ready2}, 32'd1);
        din = 32'h1234; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        chk("post_rst_valid", {31'h0, out_valid2}, 32'd1);
        chk("post_rst_data", {16'h0, out_data2}, 32'h1234);
        chk("post_rst_count", {30'h0, count2}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
